// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe -- pipelined multiply-accumulate for one convolution output.
//
// Each accepted beat carries NUM (weight, pixel) taps. Their exact signed x
// unsigned products and one bias leaf are reduced by a registered adder tree.
// CH consecutive beats are then accumulated into one saturated result.
//
// Pipeline:
//   product register -> T tree levels -> accumulator (output) register
//   T = ceil(log2(NUM+1)).
//   For the last pass of a result, out_valid rises T+1 edges after the edge
//   that accepted that beat.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   tap vector present
//   in_ready   beat accepted when in_valid & in_ready at an edge
//   wei        signed weights, tap j at [j*DATA +: DATA]
//   ima        unsigned pixels, tap j at [j*IMA +: IMA]
//   bias       signed bias, used on the first pass of a result only
//   out_valid  result available; held until out_valid & out_ready
//   out_ready  downstream accepts the result
//   out_data   signed, saturated result (OUT_W bits)
//   out_sat    1 when out_data was clipped
//
// Build option:
//   CONV_MAC_RELU_EN  when defined, negative results are clamped to 0 before
//                     saturation, and out_sat stays 0 for them.
module conv_mac_pipe #(
   parameter int DATA       = 16,
   parameter int IMA        = 8,
   parameter int NUM        = 49,
   parameter int CH         = 1,
   parameter int BIAS_SHIFT = 8,
   parameter int OUT_W      = 39
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA*NUM-1:0] wei,
   input  logic [IMA*NUM-1:0]  ima,
   input  logic [DATA-1:0]     bias,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_sat
);

   localparam int T      = $clog2(NUM + 1);
   localparam int LEAVES = NUM + 1;
   localparam int PROD_W = DATA + IMA + 1;
   localparam int ACC_W  = PROD_W + T + $clog2(CH) + BIAS_SHIFT;
   localparam int CNT_W  = (CH > 1) ? $clog2(CH) : 1;

   // Number of nodes at tree level l (level 0 = leaves).
   function automatic int lvl_cnt(input int l);
      return (LEAVES + (1 << l) - 1) >> l;
   endfunction

   logic                    stall;
   logic                    accept;
   logic [CNT_W-1:0]        pass_cnt_reg;
   logic                    pass_first;
   logic                    pass_last;
   logic [T:0]              vld_reg;
   logic [T:0]              first_reg;
   logic [T:0]              last_reg;
   logic signed [ACC_W-1:0] bias_leaf;
   logic signed [ACC_W-1:0] tree_out;
   logic signed [ACC_W-1:0] acc_reg;
   logic                    out_valid_reg;
   logic signed [ACC_W-1:0] res_next;
   logic signed [PROD_W-1:0] prod [NUM];

   // A held result freezes every stage, so nothing can overrun it.
   assign stall      = out_valid_reg & ~out_ready;
   assign in_ready   = ~stall;
   assign accept     = in_valid & in_ready;
   assign out_valid  = out_valid_reg;

   assign pass_first = (pass_cnt_reg == '0);
   assign pass_last  = (pass_cnt_reg == CNT_W'(CH - 1));

   // Bias contributes only once per result, on its first pass.
   assign bias_leaf  = pass_first ?
                       ({{(ACC_W-DATA){bias[DATA-1]}}, bias} << BIAS_SHIFT) : '0;

   // Exact signed x unsigned products: the pixel gets a zero sign bit.
   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM; gi++) begin : g_mul
         assign prod[gi] = $signed(wei[gi*DATA +: DATA]) *
                           $signed({1'b0, ima[gi*IMA +: IMA]});
      end
   endgenerate

   // Pass counter and per-stage valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg      <= '0;
         pass_cnt_reg <= '0;
      end else if (!stall) begin
         vld_reg <= {vld_reg[T-1:0], accept};
         if (accept)
            pass_cnt_reg <= pass_last ? '0 : pass_cnt_reg + 1'b1;
      end
   end

   // First/last markers travel alongside the data.
   always_ff @(posedge clk) begin
      if (!stall) begin
         first_reg <= {first_reg[T-1:0], pass_first};
         last_reg  <= {last_reg[T-1:0], pass_last};
      end
   end

   // Adder tree. Every node is already ACC_W wide, so an odd node passes
   // straight through with its sign extension intact.
   generate
      for (gi = 0; gi <= T; gi++) begin : g_lvl
         localparam int N = lvl_cnt(gi);
         logic signed [ACC_W-1:0] node_reg [N];

         if (gi == 0) begin : g_leaf
            always_ff @(posedge clk) begin
               if (accept) begin
                  for (int k = 0; k < NUM; k++)
                     node_reg[k] <= {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
                  node_reg[NUM] <= bias_leaf;
               end
            end
         end else begin : g_sum
            localparam int NP = lvl_cnt(gi - 1);
            for (gj = 0; gj < N; gj++) begin : g_node
               if (2*gj + 1 < NP) begin : g_add
                  always_ff @(posedge clk) begin
                     if (!stall)
                        node_reg[gj] <= g_lvl[gi-1].node_reg[2*gj] +
                                        g_lvl[gi-1].node_reg[2*gj+1];
                  end
               end else begin : g_pass
                  always_ff @(posedge clk) begin
                     if (!stall)
                        node_reg[gj] <= g_lvl[gi-1].node_reg[2*gj];
                  end
               end
            end
         end
      end
   endgenerate

   assign tree_out = g_lvl[T].node_reg[0];

   // Accumulator doubles as the output register. It loads on a first pass
   // and adds on later passes. out_valid rises only after a last pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else if (!stall) begin
         out_valid_reg <= vld_reg[T] & last_reg[T];
         if (vld_reg[T])
            acc_reg <= first_reg[T] ? tree_out : acc_reg + tree_out;
      end
   end

   always_comb begin
      res_next = acc_reg;
`ifdef CONV_MAC_RELU_EN
      if (acc_reg[ACC_W-1])
         res_next = '0;
`endif
   end

   generate
      if (ACC_W > OUT_W) begin : g_sat
         localparam logic signed [ACC_W-1:0] SAT_MAX =
            {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
         localparam logic signed [ACC_W-1:0] SAT_MIN =
            {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
         always_comb begin
            out_data = res_next[OUT_W-1:0];
            out_sat  = 1'b0;
            if (res_next > SAT_MAX) begin
               out_data = SAT_MAX[OUT_W-1:0];
               out_sat  = 1'b1;
            end else if (res_next < SAT_MIN) begin
               out_data = SAT_MIN[OUT_W-1:0];
               out_sat  = 1'b1;
            end
         end
      end else begin : g_nosat
         assign out_data = OUT_W'(res_next);
         assign out_sat  = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed testbench for conv_mac_pipe.
//
// Three instances are used:
//   u_a  default parameters (CH=1)
//   u_b  CH=3, with its own reset
//   u_c  OUT_W=16, for saturation
module tb_conv_mac_pipe;
   localparam int DATA = 16;
   localparam int IMA  = 8;
   localparam int NUM  = 49;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst_b;

   logic                in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sat_a;
   logic [DATA*NUM-1:0] wei_a;
   logic [IMA*NUM-1:0]  ima_a;
   logic [DATA-1:0]     bias_a;
   logic [38:0]         out_data_a;

   logic                in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b;
   logic [DATA*NUM-1:0] wei_b;
   logic [IMA*NUM-1:0]  ima_b;
   logic [DATA-1:0]     bias_b;
   logic [38:0]         out_data_b;

   logic                in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_sat_c;
   logic [DATA*NUM-1:0] wei_c;
   logic [IMA*NUM-1:0]  ima_c;
   logic [DATA-1:0]     bias_c;
   logic [15:0]         out_data_c;

   int n_vec = 0;
   int n_err = 0;

   conv_mac_pipe u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .wei(wei_a), .ima(ima_a), .bias(bias_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_data(out_data_a), .out_sat(out_sat_a)
   );

   conv_mac_pipe #(.CH(3)) u_b (
      .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .wei(wei_b), .ima(ima_b), .bias(bias_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_data(out_data_b), .out_sat(out_sat_b)
   );

   conv_mac_pipe #(.OUT_W(16)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .wei(wei_c), .ima(ima_c), .bias(bias_c), .out_valid(out_valid_c),
      .out_ready(out_ready_c), .out_data(out_data_c), .out_sat(out_sat_c)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   function automatic longint exp_relu(input longint v);
`ifdef CONV_MAC_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [DATA*NUM-1:0] rep_w(input logic [DATA-1:0] w);
      logic [DATA*NUM-1:0] v;
      for (int j = 0; j < NUM; j++) v[j*DATA +: DATA] = w;
      return v;
   endfunction

   function automatic logic [IMA*NUM-1:0] rep_i(input logic [IMA-1:0] p);
      logic [IMA*NUM-1:0] v;
      for (int j = 0; j < NUM; j++) v[j*IMA +: IMA] = p;
      return v;
   endfunction

   task automatic beat_a(input logic [15:0] w, input logic [7:0] p, input logic [15:0] b);
      @(negedge clk);
      in_valid_a = 1'b1; wei_a = rep_w(w); ima_a = rep_i(p); bias_a = b;
   endtask

   task automatic beat_b(input logic [15:0] w, input logic [7:0] p, input logic [15:0] b);
      @(negedge clk);
      in_valid_b = 1'b1; wei_b = rep_w(w); ima_b = rep_i(p); bias_b = b;
   endtask

   task automatic beat_c(input logic [15:0] w, input logic [7:0] p, input logic [15:0] b);
      @(negedge clk);
      in_valid_c = 1'b1; wei_c = rep_w(w); ima_c = rep_i(p); bias_c = b;
   endtask

   // Counts edges until out_valid is seen, within a bounded number of cycles.
   task automatic wait_a(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid_a && n < 40);
      chk("a_valid_seen", out_valid_a, 1);
   endtask

   task automatic wait_b(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid_b && n < 40);
      chk("b_valid_seen", out_valid_b, 1);
   endtask

   task automatic wait_c(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid_c && n < 40);
      chk("c_valid_seen", out_valid_c, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;
      rst = 1'b1; rst_b = 1'b1;
      in_valid_a = 1'b0; out_ready_a = 1'b1; wei_a = '0; ima_a = '0; bias_a = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b1; wei_b = '0; ima_b = '0; bias_b = '0;
      in_valid_c = 1'b0; out_ready_c = 1'b1; wei_c = '0; ima_c = '0; bias_c = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_a_valid", out_valid_a, 0);
      chk("rst_a_data", out_data_a, 0);
      chk("rst_a_sat", out_sat_a, 0);
      chk("rst_a_ready", in_ready_a, 1);
      chk("rst_b_valid", out_valid_b, 0);
      chk("rst_b_ready", in_ready_b, 1);

      // 49 taps of 1*2, no bias: 98, latency 7 edges
      beat_a(16'd1, 8'd2, 16'd0);
      @(negedge clk); in_valid_a = 1'b0;
      wait_a(n);
      chk("a1_latency", n, 7);
      chk("a1_data", $signed(out_data_a), 98);
      chk("a1_sat", out_sat_a, 0);
      @(posedge clk); #1;
      chk("a1_valid_drop", out_valid_a, 0);

      // Bias 3<<8 = 768 -> 866; next beat bias -1 -> -256 + 98 = -158
      beat_a(16'd3, 8'd2, 16'd3);
      wei_a = rep_w(16'd1);
      beat_a(16'd1, 8'd2, 16'hFFFF);
      @(negedge clk); in_valid_a = 1'b0;
      wait_a(n);
      chk("a2_latency", n, 6);
      chk("a2_data_bias3", $signed(out_data_a), 866);
      @(posedge clk); #1;
      chk("a2_b2b_valid", out_valid_a, 1);
      chk("a2_data_biasm1", $signed(out_data_a), exp_relu(-158));
      @(posedge clk); #1;
      chk("a2_valid_drop", out_valid_a, 0);

      // CH=3: three passes of 49*(-255) = -12495 -> -37485
      beat_b(16'hFFFF, 8'd255, 16'd0);
      beat_b(16'hFFFF, 8'd255, 16'd0);
      beat_b(16'hFFFF, 8'd255, 16'd0);
      @(negedge clk); in_valid_b = 1'b0;
      wait_b(n);
      chk("b1_latency", n, 7);
      chk("b1_data", $signed(out_data_b), exp_relu(-37485));
      chk("b1_sat", out_sat_b, 0);
      @(posedge clk); #1;
      chk("b1_valid_drop", out_valid_b, 0);

      // Reset after two of three passes: no result may come out
      beat_b(16'hFFFF, 8'd255, 16'd5);
      beat_b(16'hFFFF, 8'd255, 16'd5);
      @(negedge clk); in_valid_b = 1'b0; rst_b = 1'b1;
      @(negedge clk); rst_b = 1'b0;
      cnt = 0;
      repeat (12) begin @(posedge clk); #1; if (out_valid_b) cnt++; end
      chk("b2_rst_quiet", cnt, 0);
      chk("b2_rst_ready", in_ready_b, 1);
      // Fresh result: 3 * 49 * 2 * 10 = 2940
      beat_b(16'd2, 8'd10, 16'd0);
      beat_b(16'd2, 8'd10, 16'd0);
      beat_b(16'd2, 8'd10, 16'd0);
      @(negedge clk); in_valid_b = 1'b0;
      wait_b(n);
      chk("b2_latency", n, 7);
      chk("b2_data", $signed(out_data_b), 2940);

      // Backpressure: beats k=1..8 give 49*k in order, first result held 5 cycles
      out_ready_a = 1'b0;
      fork
         begin
            int k;
            k = 1;
            while (k <= 8) begin
               @(negedge clk);
               in_valid_a = 1'b1; wei_a = rep_w(16'd1); ima_a = rep_i(8'(k)); bias_a = '0;
               #4;
               if (in_ready_a) k++;
            end
            @(negedge clk); in_valid_a = 1'b0;
         end
         begin
            int m;
            logic [38:0] held;
            wait_a(m);
            chk("st_first", $signed(out_data_a), 49);
            held = out_data_a;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("st_in_ready", in_ready_a, 0);
               chk("st_valid_hold", out_valid_a, 1);
               chk("st_data_hold", out_data_a, held);
            end
            out_ready_a = 1'b1;
            for (int r = 2; r <= 8; r++) begin
               wait_a(m);
               chk("st_stream", $signed(out_data_a), 49 * r);
            end
            @(posedge clk); #1;
            chk("st_no_extra", out_valid_a, 0);
         end
      join

      // Saturation at OUT_W=16: 49*32767*255 clips high
      beat_c(16'd32767, 8'd255, 16'd0);
      @(negedge clk); in_valid_c = 1'b0;
      wait_c(n);
      chk("c_pos_data", $signed(out_data_c), 32767);
      chk("c_pos_sat", out_sat_c, 1);
      // 49*(-32768)*255 clips low (or clamps to 0 with ReLU)
      beat_c(16'h8000, 8'd255, 16'd0);
      @(negedge clk); in_valid_c = 1'b0;
      wait_c(n);
`ifdef CONV_MAC_RELU_EN
      chk("c_neg_data", $signed(out_data_c), 0);
      chk("c_neg_sat", out_sat_c, 0);
`else
      chk("c_neg_data", $signed(out_data_c), -32768);
      chk("c_neg_sat", out_sat_c, 1);
`endif
      // In range: 49*3*4 - 256 = 332
      beat_c(16'd3, 8'd4, 16'hFFFF);
      @(negedge clk); in_valid_c = 1'b0;
      wait_c(n);
      chk("c_mid_data", $signed(out_data_c), 332);
      chk("c_mid_sat", out_sat_c, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_mac_pipe.md
CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 SHALL have parameter DATA, 16, signed weight/bias width.
REQ-002 SHALL have parameter IMA, 8, unsigned pixel width.
REQ-003 SHALL have parameter NUM, 49, taps per pass (1..256).
REQ-004 SHALL have parameter CH, 1, input channels accumulated per result (1..1024).
REQ-005 SHALL have parameter BIAS_SHIFT, 8, left shift applied to bias before summation.
REQ-006 SHALL have parameter OUT_W, 39, signed result width.
REQ-007 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port in_valid  in  1  tap vector present.
REQ-010 SHALL have port in_ready  out  1  beat accepted when in_valid&in_ready at an edge.
REQ-011 SHALL have port wei  in  DATA*NUM  signed weights, tap j at [j*DATA +: DATA].
REQ-012 SHALL have port ima  in  IMA*NUM  unsigned pixels, tap j at [j*IMA +: IMA].
REQ-013 SHALL have port bias  in  DATA  signed bias, sampled on the first pass only.
REQ-014 SHALL have ports out_valid out 1, out_ready in 1, out_data out OUT_W (signed result), out_sat out 1 (saturation flag).

Function
REQ-015 SHALL compute per pass P = sum over j of signed(wei_j)*unsigned(ima_j), exact, no truncation.
REQ-016 SHALL define T = ceil(log2(NUM+1)); adder tree of T registered levels with NUM products plus one bias leaf; odd leaf passes through with sign extension.
REQ-017 SHALL feed the bias leaf sign-extended (bias << BIAS_SHIFT) on the first pass of a result and zero on other passes.
REQ-018 SHALL size accumulator ACC_W = DATA+IMA+1+T+clog2(CH)+BIAS_SHIFT bits; no internal overflow for any input.
REQ-019 SHALL pipeline as: product register, T tree levels, accumulator register; result on last pass registered T+1 edges after the accepting edge when unstalled.
REQ-020 SHALL keep a pass counter 0..CH-1 incremented per accepted beat, wrapping to 0 after CH-1; first/last flags travel with data down the pipe.
REQ-021 SHALL load accumulator on a first-pass beat and add on later beats; CH=1 makes every beat first and last.
REQ-022 SHALL assert out_valid after the last-pass accumulation and hold out_data, out_sat stable until out_valid&out_ready.
REQ-023 SHALL stall the whole pipeline (all stages, counter) while out_valid&!out_ready; in_ready = !(out_valid&!out_ready).
REQ-024 SHALL allow out_valid to stay high back-to-back when out_ready=1 and in_valid is continuous (one result per CH beats).
REQ-025 SHALL saturate accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1], setting out_sat=1 when clipped, else 0.
REQ-026 SHALL ignore wei/ima/bias when the beat is not accepted; bubbles propagate as invalid stages.

Reset
REQ-027 SHALL on rst clear all stage valids, pass counter, accumulator; out_valid=0, out_data=0, out_sat=0; in_ready=1 the cycle after rst deasserts.
REQ-028 SHALL on rst mid-result discard partial sums; next accepted beat is a first pass.

Configuration
REQ-029 SHALL, with CONV_MAC_RELU_EN defined, clamp negative results to 0 before saturation (out_sat=0 for such results); without it, signed results pass unchanged.

Verification
REQ-030 SHALL test NUM=49,CH=1, all wei=1, ima=2, bias=0, out_ready=1 -> out_data=98, out_valid 7 edges after accept.
REQ-031 SHALL test same, bias=3, BIAS_SHIFT=8 -> out_data=866; next beat bias=-1 -> out_data=-158.
REQ-032 SHALL test CH=3, three beats wei=-1, ima=255, bias=0 (macro off) -> single out_data=-37485 after third beat; with CONV_MAC_RELU_EN -> 0.
REQ-033 SHALL test OUT_W=16, wei=32767, ima=255 -> out_data=32767, out_sat=1.
REQ-034 SHALL test out_ready held low 5 cycles with in_valid high -> in_ready=0, out_data stable, no beat lost or duplicated.
REQ-035 SHALL test rst pulse after 2 of 3 passes (CH=3) -> no output; following 3 beats produce correct fresh result.
